// File: rtl/nios32_cpu_ocimem_arbiter.sv
// Sysclk-side sequencer for the Nios32 OCI debug RAM. Holds a one-deep JTAG
// command slot with an auto-incrementing address and shares the single RAM
// port round-robin with the CPU Avalon debug slave.
module nios32_cpu_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // JTAG debug module strobes and payload
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  // CPU Avalon debug slave
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_waitrequest,
  // Single-port RAM
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_J_ACC,
    S_J_CAP,
    S_C_ACC,
    S_C_CAP
  } state_t;

  state_t              r_state;
  state_t              w_next;

  // JTAG command slot
  logic                r_jpend;
  logic                r_jwr;
  logic [31:0]         r_jwdata;
  logic [ADDR_W-1:0]   r_jaddr;

  // CPU request captured at grant so a dropped cpu_req cannot corrupt the access
  logic                r_cwr;
  logic [ADDR_W-1:0]   r_caddr;
  logic [31:0]         r_cwdata;

  logic                r_last_grant_j;  // 1: JTAG was granted most recently
  logic                r_cpu_done;

  logic                w_grant_j;
  logic                w_grant_c;
  logic                w_jreq;
  logic                w_creq;
  logic                w_jdone;
  logic                w_cdone;
  logic                w_jbusy;
  logic                w_any_strobe;
  logic                w_jdo_unused;

  // Payload bits not carried by any command field
  assign w_jdo_unused = ^{jdo[37:35], jdo[2:0]};

  assign w_jreq       = r_jpend;
  // A CPU request whose done pulse is showing is the one just served
  assign w_creq       = cpu_req & ~r_cpu_done;
  assign w_jbusy      = r_jpend | (r_state == S_J_ACC) | (r_state == S_J_CAP);
  assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_jdone      = ((r_state == S_J_ACC) & r_jwr) | (r_state == S_J_CAP);
  assign w_cdone      = ((r_state == S_C_ACC) & r_cwr) | (r_state == S_C_CAP);

  assign cpu_waitrequest = cpu_req & ~r_cpu_done;

  // Next-state, grant and RAM port decode from the state register
  always_comb begin
    w_next    = r_state;
    w_grant_j = 1'b0;
    w_grant_c = 1'b0;
    ram_addr  = r_jaddr;
    ram_wdata = r_jwdata;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_jreq && w_creq) begin
          if (r_last_grant_j) w_grant_c = 1'b1;
          else                w_grant_j = 1'b1;
        end else if (w_jreq) begin
          w_grant_j = 1'b1;
        end else if (w_creq) begin
          w_grant_c = 1'b1;
        end
        if (w_grant_j)      w_next = S_J_ACC;
        else if (w_grant_c) w_next = S_C_ACC;
      end
      S_J_ACC: begin
        ram_addr  = r_jaddr;
        ram_wdata = r_jwdata;
        ram_we    = r_jwr;
        ram_re    = ~r_jwr;
        w_next    = r_jwr ? S_IDLE : S_J_CAP;
      end
      S_J_CAP: w_next = S_IDLE;
      S_C_ACC: begin
        ram_addr  = r_caddr;
        ram_wdata = r_cwdata;
        ram_we    = r_cwr;
        ram_re    = ~r_cwr;
        w_next    = r_cwr ? S_IDLE : S_C_CAP;
      end
      S_C_CAP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, round-robin history, CPU capture and CPU read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_last_grant_j <= 1'b0;
      r_cwr          <= 1'b0;
      r_caddr        <= '0;
      r_cwdata       <= '0;
      r_cpu_done     <= 1'b0;
      cpu_rdata      <= '0;
    end else begin
      r_state    <= w_next;
      r_cpu_done <= w_cdone;
      if (w_grant_j) r_last_grant_j <= 1'b1;
      if (w_grant_c) begin
        r_last_grant_j <= 1'b0;
        r_cwr          <= cpu_write;
        r_caddr        <= cpu_addr;
        r_cwdata       <= cpu_wdata;
      end
      if (r_state == S_C_CAP) cpu_rdata <= ram_rdata;
    end
  end

  // JTAG slot: strobe acceptance/overrun, completion, address and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jpend       <= 1'b0;
      r_jwr         <= 1'b0;
      r_jwdata      <= '0;
      r_jaddr       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      // Completion only happens while busy, so it never meets an accepted strobe
      if (w_jdone) begin
        r_jpend       <= 1'b0;
        r_jaddr       <= r_jaddr + 1'b1;
        monitor_ready <= 1'b1;
      end
      if (r_state == S_J_CAP) MonDReg <= ram_rdata;
      if (w_any_strobe) begin
        if (w_jbusy) begin
          monitor_error <= 1'b1;
        end else begin
          monitor_ready <= 1'b0;
          if (take_action_ocimem_a) begin
            r_jaddr       <= jdo[ADDR_W+16:17];
            monitor_error <= 1'b0;
            if (jdo[34]) begin
              r_jpend <= 1'b1;
              r_jwr   <= 1'b0;
            end
          end else if (take_action_ocimem_b) begin
            r_jpend  <= 1'b1;
            r_jwr    <= 1'b1;
            r_jwdata <= jdo[34:3];
          end else begin
            r_jpend <= 1'b1;
            r_jwr   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nios32_cpu_ocimem_arbiter.sv
// Bench for the OCI memory arbiter: a behavioural RAM, a scoreboard of
// expected RAM accesses in grant order, and directed JTAG/CPU sequences.
module tb_nios32_cpu_ocimem_arbiter;

  localparam int KA = 0;  // take_action_ocimem_a
  localparam int KN = 1;  // take_no_action_ocimem_a
  localparam int KB = 2;  // take_action_ocimem_b

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [37:0] jdo;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic        cpu_req, cpu_write;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_re, ram_we;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } acc_t;
  acc_t sb_q[$];

  // Bench-side RAM (DUT target) and expectation shadow, each with its own writer
  logic [31:0] mem [256];
  bit   [255:0] mem_wr;
  logic [31:0] exp_mem [256];
  bit   [255:0] exp_wr;

  always #5 clk = ~clk;

  nios32_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .jdo(jdo), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    if (a == 8'h20) return 32'h1234_5678;
    if (a == 8'h21) return 32'hCAFE_F00D;
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RAM model: registered read data one cycle after ram_re
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      mem_wr[ram_addr] <= 1'b1;
    end
    if (ram_re) ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
  end

  // Scoreboard consumer: every RAM access must match the next expected one
  always @(negedge clk) begin
    if (ram_re || ram_we) begin
      if (sb_q.size() == 0) begin
        chk("ram_unexpected", {ram_we, ram_re, ram_addr, ram_wdata}, 64'd0);
      end else begin
        acc_t e;
        e = sb_q.pop_front();
        chk("ram_op", {ram_we, ram_re}, e.we ? 2'b10 : 2'b01);
        chk("ram_addr", ram_addr, e.addr);
        if (e.we) chk("ram_wdata", ram_wdata, e.data);
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    return exp_wr[a] ? exp_mem[a] : pat(a);
  endfunction

  task automatic exp_acc(input logic we, input logic [7:0] a, input logic [31:0] d);
    acc_t e;
    e.we = we; e.addr = a; e.data = d;
    sb_q.push_back(e);
    if (we) begin
      exp_mem[a] = d;
      exp_wr[a]  = 1'b1;
    end
  endtask

  function automatic logic [37:0] mkj(input logic [7:0] a, input logic rd);
    logic [37:0] d;
    d = '0;
    d[24:17] = a;
    d[34] = rd;
    return d;
  endfunction

  function automatic logic [37:0] mkd(input logic [31:0] x);
    logic [37:0] d;
    d = '0;
    d[34:3] = x;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one strobe for one sampling edge; returns at edge+1 (cycle 1)
  task automatic strobe(input int kind, input logic [37:0] d);
    jdo = d;
    take_action_ocimem_a    = (kind == KA);
    take_no_action_ocimem_a = (kind == KN);
    take_action_ocimem_b    = (kind == KB);
    step();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo = '0;
  endtask

  // Uncontended JTAG read: ram_re in cycle 2, result exactly in cycle 4
  task automatic jread(input string tag, input int kind, input logic [37:0] d, input logic [7:0] a);
    exp_acc(1'b0, a, 32'h0);
    strobe(kind, d);
    @(negedge clk); chk({tag, "_rdy_c1"}, monitor_ready, 1'b0);
    step(); @(negedge clk); chk({tag, "_re_c2"}, ram_re, 1'b1);
    step(); @(negedge clk); chk({tag, "_rdy_c3"}, monitor_ready, 1'b0);
    step(); @(negedge clk);
    chk({tag, "_rdy_c4"}, monitor_ready, 1'b1);
    chk({tag, "_data"}, MonDReg, exp_rd(a));
  endtask

  // Counts cycles from the current one until waitrequest is low (bounded)
  task automatic cpu_wait(output int n);
    n = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin
        n = i;
        break;
      end
      step();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    reset_n = 1'b0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    jdo = '0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", monitor_ready, 1'b0);
    chk("rst_error", monitor_error, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_ram_en", {ram_re, ram_we}, 2'b00);
    cpu_req = 1'b1; #1;
    chk("rst_waitreq", cpu_waitrequest, 1'b1);
    cpu_req = 1'b0;
    step(); reset_n = 1'b1;
    step(); @(negedge clk);
    chk("rel_ram_en", {ram_re, ram_we}, 2'b00);
    chk("rel_ready", monitor_ready, 1'b0);

    // JTAG write to 0x10, then read back through the incremented address
    step();
    strobe(KA, mkj(8'h10, 1'b0));
    exp_acc(1'b1, 8'h10, 32'hDEAD_BEEF);
    strobe(KB, mkd(32'hDEAD_BEEF));
    step(); @(negedge clk);
    chk("wr_we_c2", ram_we, 1'b1);
    chk("wr_rdy_c2", monitor_ready, 1'b0);
    step(); @(negedge clk);
    chk("wr_rdy_c3", monitor_ready, 1'b1);
    step();
    jread("incr11", KN, '0, 8'h11);

    // JTAG read with auto-increment
    step(); jread("rd20", KA, mkj(8'h20, 1'b1), 8'h20);
    step(); jread("rd21", KN, '0, 8'h21);

    // Overrun: second write dropped, error sticky until next _a
    step();
    strobe(KA, mkj(8'h40, 1'b0));
    exp_acc(1'b1, 8'h40, 32'hA1A1_A1A1);
    strobe(KB, mkd(32'hA1A1_A1A1));
    strobe(KB, mkd(32'hB2B2_B2B2));
    @(negedge clk); chk("ovr_err_c2", monitor_error, 1'b1);
    step(); @(negedge clk);
    chk("ovr_rdy_c3", monitor_ready, 1'b1);
    chk("ovr_err_c3", monitor_error, 1'b1);
    step(); jread("ovr_rb40", KA, mkj(8'h40, 1'b1), 8'h40);
    chk("ovr_err_clr", monitor_error, 1'b0);

    // Address wrap 0xFF -> 0x00
    step(); jread("wrap_ff", KA, mkj(8'hFF, 1'b1), 8'hFF);
    step(); jread("wrap_00", KN, '0, 8'h00);
    chk("wrap_err", monitor_error, 1'b0);

    // Contention after reset: JTAG wins first tie, CPU waits 3 extra cycles
    step(); reset_n = 1'b0; step(); reset_n = 1'b1; step();
    exp_acc(1'b0, 8'h30, 32'h0);
    exp_acc(1'b0, 8'h31, 32'h0);
    strobe(KA, mkj(8'h30, 1'b1));
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h31;
    cpu_wait(n);
    chk("tie1_cpu_lat", n, 6);
    chk("tie1_cpu_rdata", cpu_rdata, exp_rd(8'h31));
    chk("tie1_mondreg", MonDReg, exp_rd(8'h30));
    step(); cpu_req = 1'b0;
    // Lone JTAG write (jaddr now 0x31) makes JTAG the last grantee
    exp_acc(1'b1, 8'h31, 32'h55AA_55AA);
    strobe(KB, mkd(32'h55AA_55AA));
    step(); step(); @(negedge clk);
    chk("tie_mid_rdy", monitor_ready, 1'b1);
    // Second tie: CPU write first, then JTAG read of 0x32
    step();
    exp_acc(1'b1, 8'h33, 32'h0BAD_F00D);
    exp_acc(1'b0, 8'h32, 32'h0);
    strobe(KN, '0);
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h33; cpu_wdata = 32'h0BAD_F00D;
    cpu_wait(n);
    chk("tie2_cpu_lat", n, 2);
    step(); cpu_req = 1'b0; cpu_write = 1'b0;
    step(); @(negedge clk);
    chk("tie2_rdy_c5", monitor_ready, 1'b0);
    step(); @(negedge clk);
    chk("tie2_rdy_c6", monitor_ready, 1'b1);
    chk("tie2_mondreg", MonDReg, exp_rd(8'h32));

    // Uncontended CPU read of the CPU-written word
    step();
    exp_acc(1'b0, 8'h33, 32'h0);
    cpu_req = 1'b1; cpu_addr = 8'h33;
    cpu_wait(n);
    chk("cpu_rd_lat", n, 3);
    chk("cpu_rd_data", cpu_rdata, 32'h0BAD_F00D);
    step(); cpu_req = 1'b0;

    // Reset during J_CAP: enables drop at once, MonDReg never loads
    step();
    exp_acc(1'b0, 8'h60, 32'h0);
    strobe(KA, mkj(8'h60, 1'b1));
    step(); step();
    reset_n = 1'b0; #1;
    chk("mrst_ram_en", {ram_re, ram_we}, 2'b00);
    chk("mrst_mondreg", MonDReg, 32'h0);
    chk("mrst_ready", monitor_ready, 1'b0);
    step(); step(); reset_n = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("mrst_after_mondreg", MonDReg, 32'h0);
    chk("mrst_after_ready", monitor_ready, 1'b0);
    chk("mrst_after_err", monitor_error, 1'b0);

    step();
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
